// File: rtl/lcd_spi_tx.sv
// lcd_spi_tx: ST7789 SPI serializer with CS framing and a valid/ready word input
module lcd_spi_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] in_data,
  input  logic       in_last,
  output logic       busy,
  output logic       lcd_clk,
  output logic       lcd_cs,
  output logic       lcd_rs,
  output logic       lcd_data
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, WAIT, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shf, shf_n;
  logic last_q, last_n;
  logic clk_n, cs_n, rs_n, data_n;
  logic acc, done;
  assign in_ready = state == IDLE || state == WAIT;
  assign busy = state != IDLE;
  assign acc = in_valid && in_ready;
  assign done = cnt == TOP;
  // next state and next registered LCD pin values; every timed phase lasts CLK_DIV cycles
  always_comb begin
    state_n = state;
    idx_n = idx;
    shf_n = shf;
    last_n = last_q;
    clk_n = lcd_clk;
    cs_n = lcd_cs;
    rs_n = lcd_rs;
    data_n = lcd_data;
    case (state)
      IDLE, WAIT: if (acc) begin
        state_n = SETUP;
        cs_n = 1'b0;
        rs_n = in_data[8];
        data_n = in_data[7];
        idx_n = 3'd7;
        shf_n = in_data[7:0];
        last_n = in_last;
      end
      SETUP, LOW: if (done) begin
        state_n = HIGH;
        clk_n = 1'b1;
      end
      HIGH: if (done) begin
        clk_n = 1'b0;
        state_n = idx == 3'd0 ? HOLD : LOW;
        idx_n = idx == 3'd0 ? idx : idx - 3'd1;
        data_n = idx == 3'd0 ? lcd_data : shf[idx - 3'd1];
      end
      HOLD: if (done) begin
        state_n = last_q ? GAP : WAIT;
        cs_n = last_q;
        rs_n = last_q ? 1'b1 : lcd_rs;
        data_n = last_q ? 1'b1 : lcd_data;
      end
      GAP: if (done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    cnt_n = (state_n != state || state == IDLE || state == WAIT) ? '0 : cnt + 1'b1;
  end
  // state, phase counter, latched word and registered LCD pins
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      idx <= 3'd0;
      shf <= 8'd0;
      last_q <= 1'b0;
      lcd_clk <= 1'b0;
      lcd_cs <= 1'b1;
      lcd_rs <= 1'b1;
      lcd_data <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shf <= shf_n;
      last_q <= last_n;
      lcd_clk <= clk_n;
      lcd_cs <= cs_n;
      lcd_rs <= rs_n;
      lcd_data <= data_n;
    end
  end
endmodule

// File: tb/tb_lcd_spi_tx.sv
// tb_lcd_spi_tx: directed bench for lcd_spi_tx with CLK_DIV=2 and CLK_DIV=1 instances
module tb_lcd_spi_tx;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic vld[2], lst[2], rdy[2], bsy[2], cs[2], ck[2], rs[2], dt[2];
  logic [8:0] dat[2];
  logic [63:0] bits[2], rsb[2];
  logic pck[2], pcs[2];
  int nb[2], acc[2], bad_acc[2], wb[2], cs_rises[2], tick[2], lr[2], bad_per[2];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  lcd_spi_tx #(.CLK_DIV(2)) d2 (.clk(clk), .resetn(resetn), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_data(dat[0]), .in_last(lst[0]), .busy(bsy[0]), .lcd_clk(ck[0]), .lcd_cs(cs[0]),
    .lcd_rs(rs[0]), .lcd_data(dt[0]));
  lcd_spi_tx #(.CLK_DIV(1)) d1 (.clk(clk), .resetn(resetn), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_data(dat[1]), .in_last(lst[1]), .busy(bsy[1]), .lcd_clk(ck[1]), .lcd_cs(cs[1]),
    .lcd_rs(rs[1]), .lcd_data(dt[1]));
  // LCD-side model: sample data/rs on each lcd_clk rise, count CS releases and accepts
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      pck[i] <= ck[i];
      pcs[i] <= cs[i];
      tick[i] <= tick[i] + 1;
      if (vld[i] && rdy[i] && resetn) begin
        acc[i] <= acc[i] + 1;
        wb[i] <= 0;
        if (!cs[i] && wb[i] != 8) bad_acc[i] <= bad_acc[i] + 1;
      end else if (ck[i] && !pck[i]) begin
        bits[i] <= {bits[i][62:0], dt[i]};
        rsb[i] <= {rsb[i][62:0], rs[i]};
        nb[i] <= nb[i] + 1;
        wb[i] <= wb[i] + 1;
        lr[i] <= tick[i];
        if (wb[i] > 0 && tick[i] - lr[i] != (i == 1 ? 2 : 4)) bad_per[i] <= bad_per[i] + 1;
      end
      if (cs[i] && !pcs[i]) cs_rises[i] <= cs_rises[i] + 1;
    end
  end
  task automatic send(input int i, input logic [8:0] d, input logic l);
    int n = 0;
    vld[i] = 1'b1;
    dat[i] = d;
    lst[i] = l;
    while (!rdy[i] && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL send_timeout word=%h ready=%b wanted 1", d, rdy[i]);
    end
    @(negedge clk);
    vld[i] = 1'b0;
  endtask
  task automatic wait_idle(input int i);
    int n = 0;
    while (bsy[i] && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL idle_timeout busy=%b wanted 0", bsy[i]);
    end
  endtask
  task automatic word_len(input int i, output int lo, output int g);
    lo = 0;
    g = 0;
    while (!cs[i] && lo < 400) begin
      lo++;
      @(negedge clk);
    end
    while (!rdy[i] && g < 400) begin
      g++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    vld[0] = 1'b1;
    dat[0] = 9'h1FF;
    repeat (2) @(negedge clk);
    checks++;
    if ({cs[0], ck[0], rs[0], dt[0], bsy[0], rdy[0]} !== 6'b101101) begin
      errors++;
      $display("FAIL reset_outputs got cs,ck,rs,dt,busy,rdy=%b wanted 101101",
        {cs[0], ck[0], rs[0], dt[0], bsy[0], rdy[0]});
    end
    vld[0] = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (bsy[0] !== 1'b0 || cs[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_accept busy=%b cs=%b wanted 0 1", bsy[0], cs[0]);
    end
  endtask
  task automatic test_single;
    int b0 = nb[0];
    int lo, g;
    send(0, 9'h011, 1'b1);
    word_len(0, lo, g);
    checks++;
    if (lo != 34) begin
      errors++;
      $display("FAIL single_cs_low got %0d wanted 34", lo);
    end
    checks++;
    if (g != 2) begin
      errors++;
      $display("FAIL single_ready_gap got %0d wanted 2", g);
    end
    checks++;
    if (nb[0] - b0 != 8 || bits[0][7:0] !== 8'h11) begin
      errors++;
      $display("FAIL single_bits got %0d bits byte=%h wanted 8 bits 11", nb[0] - b0, bits[0][7:0]);
    end
    checks++;
    if (rsb[0][7:0] !== 8'h00) begin
      errors++;
      $display("FAIL single_rs got %h wanted 00", rsb[0][7:0]);
    end
  endtask
  task automatic test_chain;
    int b0 = nb[0];
    int r0 = cs_rises[0];
    int a0 = bad_acc[0];
    send(0, 9'h02A, 1'b0);
    send(0, 9'h100, 1'b0);
    send(0, 9'h128, 1'b0);
    send(0, 9'h101, 1'b0);
    send(0, 9'h117, 1'b1);
    wait_idle(0);
    checks++;
    if (cs_rises[0] - r0 != 1) begin
      errors++;
      $display("FAIL chain_cs_rises got %0d wanted 1", cs_rises[0] - r0);
    end
    checks++;
    if (nb[0] - b0 != 40 || bits[0][39:0] !== 40'h2A00280117) begin
      errors++;
      $display("FAIL chain_bytes got %0d bits %h wanted 40 bits 2a00280117", nb[0] - b0, bits[0][39:0]);
    end
    checks++;
    if (rsb[0][39:0] !== 40'h00FFFFFFFF) begin
      errors++;
      $display("FAIL chain_rs got %h wanted 00ffffffff", rsb[0][39:0]);
    end
    checks++;
    if (bad_acc[0] != a0) begin
      errors++;
      $display("FAIL chain_early_accept got %0d wanted %0d", bad_acc[0], a0);
    end
  endtask
  task automatic test_pixel;
    int a0 = acc[0];
    int ba = bad_acc[0];
    int r0 = cs_rises[0];
    int n = 0;
    vld[0] = 1'b1;
    dat[0] = 9'h107;
    lst[0] = 1'b0;
    while (!rdy[0] && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    dat[0] = 9'h1E0;
    lst[0] = 1'b1;
    while (!rdy[0] && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    vld[0] = 1'b0;
    wait_idle(0);
    checks++;
    if (acc[0] - a0 != 2 || bad_acc[0] != ba) begin
      errors++;
      $display("FAIL pixel_accepts got %0d early=%0d wanted 2 early=%0d", acc[0] - a0, bad_acc[0], ba);
    end
    checks++;
    if (bits[0][15:0] !== 16'h07E0 || cs_rises[0] - r0 != 1) begin
      errors++;
      $display("FAIL pixel_value got %h rises=%0d wanted 07e0 rises=1", bits[0][15:0], cs_rises[0] - r0);
    end
  endtask
  task automatic test_backpressure;
    int a0 = acc[0];
    int b0 = nb[0];
    int low = 0;
    int n = 0;
    send(0, 9'h1A5, 1'b1);
    vld[0] = 1'b1;
    while (!cs[0] && n < 400) begin
      dat[0] = 9'($urandom);
      lst[0] = 1'($urandom);
      @(negedge clk);
      if (!bsy[0]) low++;
      n++;
    end
    vld[0] = 1'b0;
    wait_idle(0);
    checks++;
    if (acc[0] - a0 != 1) begin
      errors++;
      $display("FAIL bp_accepts got %0d wanted 1", acc[0] - a0);
    end
    checks++;
    if (low != 0) begin
      errors++;
      $display("FAIL bp_busy got %0d idle cycles wanted 0", low);
    end
    checks++;
    if (nb[0] - b0 != 8 || bits[0][7:0] !== 8'hA5 || rsb[0][7:0] !== 8'hFF) begin
      errors++;
      $display("FAIL bp_byte got %0d bits %h rs=%h wanted 8 bits a5 rs=ff", nb[0] - b0, bits[0][7:0], rsb[0][7:0]);
    end
  endtask
  task automatic test_reset_mid;
    int b0 = nb[0];
    int n = 0;
    int lo, g;
    send(0, 9'h0B2, 1'b1);
    while (nb[0] - b0 < 4 && n < 400) begin
      @(negedge clk);
      n++;
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({cs[0], ck[0], dt[0], rs[0], bsy[0]} !== 5'b10110) begin
      errors++;
      $display("FAIL midreset_outputs got cs,ck,dt,rs,busy=%b wanted 10110", {cs[0], ck[0], dt[0], rs[0], bsy[0]});
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    b0 = nb[0];
    repeat (10) @(negedge clk);
    checks++;
    if (nb[0] != b0 || cs[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_resume got rises=%0d cs=%b busy=%b wanted 0 1 0", nb[0] - b0, cs[0], bsy[0]);
    end
    send(0, 9'h036, 1'b1);
    word_len(0, lo, g);
    checks++;
    if (lo != 34 || bits[0][7:0] !== 8'h36 || rsb[0][7:0] !== 8'h00 || nb[0] - b0 != 8) begin
      errors++;
      $display("FAIL midreset_next got cs_low=%0d byte=%h rs=%h bits=%0d wanted 34 36 00 8",
        lo, bits[0][7:0], rsb[0][7:0], nb[0] - b0);
    end
  endtask
  task automatic test_min_div;
    int b0 = nb[1];
    int p0 = bad_per[1];
    int lo, g;
    send(1, 9'h155, 1'b1);
    word_len(1, lo, g);
    checks++;
    if (lo != 17 || g != 1) begin
      errors++;
      $display("FAIL mindiv_timing got cs_low=%0d gap=%0d wanted 17 1", lo, g);
    end
    checks++;
    if (bad_per[1] != p0) begin
      errors++;
      $display("FAIL mindiv_period got %0d bad periods wanted 0", bad_per[1] - p0);
    end
    checks++;
    if (nb[1] - b0 != 8 || bits[1][7:0] !== 8'h55 || rsb[1][7:0] !== 8'hFF) begin
      errors++;
      $display("FAIL mindiv_bits got %0d bits %h rs=%h wanted 8 bits 55 rs=ff", nb[1] - b0, bits[1][7:0], rsb[1][7:0]);
    end
    checks++;
    if (bad_per[0] != 0) begin
      errors++;
      $display("FAIL div2_period got %0d bad periods wanted 0", bad_per[0]);
    end
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0;
      lst[i] = 1'b0;
      dat[i] = 9'd0;
      bits[i] = '0;
      rsb[i] = '0;
      pck[i] = 1'b0;
      pcs[i] = 1'b1;
      nb[i] = 0;
      acc[i] = 0;
      bad_acc[i] = 0;
      wb[i] = 0;
      cs_rises[i] = 0;
      tick[i] = 0;
      lr[i] = 0;
      bad_per[i] = 0;
    end
    @(negedge clk);
    test_reset;
    test_single;
    test_chain;
    test_pixel;
    test_backpressure;
    test_reset_mid;
    test_min_div;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
